writeback_ctrl: RTL

Sequencer for the register-file write-back path of the memory-hierarchy processor. Accepts one issued instruction per cycle from the decode/execute stage and handles the data-memory read/write handshake (MEM_READ/MEM_WRITE vs MEM_BUSYWAIT). Stalls the PC while memory is busy, then drives the write-back mux select (0 = READDATA, 1 = ALURESULT) and the register-file write enable/address for exactly one cycle per writing instruction.

---
 rtl/writeback_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/writeback_ctrl.sv
// Write-back sequencer: memory read/write handshake, PC stall, and a one-cycle register-file write strobe.
// Optional memory-timeout abort with sticky ERROR is enabled by defining WRITEBACK_CTRL_TIMEOUT_EN.
module writeback_ctrl #(
    parameter int REG_AW  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ISSUE,
    input  logic              IS_LOAD,
    input  logic              IS_STORE,
    input  logic              WB_EN,
    input  logic [REG_AW-1:0] DEST_ADDR,
    input  logic              MEM_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic              SEL_MUX_WRITE,
    output logic              REG_WRITEENABLE,
    output logic [REG_AW-1:0] REG_WRITEADDR,
    output logic              STALL,
    output logic              ERROR
);

    typedef enum logic [1:0] {
        IDLE,
        MEM_WAIT,
        WRITEBACK
    } state_t;

    state_t            state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              sel_q, sel_d;
    logic              we_q, we_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic              is_load_q, is_load_d;

`ifdef WRITEBACK_CTRL_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`else
    // TIMEOUT is consumed only by the timeout build; referenced here so both builds share one parameter set
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        sel_d       = sel_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        dest_d      = dest_q;
        is_load_d   = is_load_q;
`ifdef WRITEBACK_CTRL_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            // The write-back cycle accepts a new instruction exactly like IDLE does
            IDLE, WRITEBACK: begin
                state_d = IDLE;
                if (ISSUE) begin
                    if (IS_LOAD) begin
                        dest_d     = DEST_ADDR;
                        is_load_d  = 1'b1;
                        mem_read_d = 1'b1;
                        state_d    = MEM_WAIT;
`ifdef WRITEBACK_CTRL_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end else if (IS_STORE) begin
                        is_load_d   = 1'b0;
                        mem_write_d = 1'b1;
                        state_d     = MEM_WAIT;
`ifdef WRITEBACK_CTRL_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end else if (WB_EN) begin
                        waddr_d = DEST_ADDR;
                        sel_d   = 1'b1;
                        we_d    = 1'b1;
                        state_d = WRITEBACK;
                    end
                end
            end
            MEM_WAIT: begin
                if (!MEM_BUSYWAIT) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (is_load_q) begin
                        sel_d   = 1'b0;
                        we_d    = 1'b1;
                        waddr_d = dest_q;
                        state_d = WRITEBACK;
                    end else begin
                        state_d = IDLE;
                    end
                end
`ifdef WRITEBACK_CTRL_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            sel_q       <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            dest_q      <= '0;
            is_load_q   <= 1'b0;
`ifdef WRITEBACK_CTRL_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            dest_q      <= dest_d;
            is_load_q   <= is_load_d;
`ifdef WRITEBACK_CTRL_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign MEM_READ        = mem_read_q;
    assign MEM_WRITE       = mem_write_q;
    assign SEL_MUX_WRITE   = sel_q;
    assign REG_WRITEENABLE = we_q;
    assign REG_WRITEADDR   = waddr_q;
    assign STALL           = (state_q == MEM_WAIT);
`ifdef WRITEBACK_CTRL_TIMEOUT_EN
    assign ERROR           = err_q;
`else
    assign ERROR           = 1'b0;
`endif

endmodule
